freq_meter: RTL and testbench

//   Gated frequency meter in the clk_32m domain, consuming divided clocks

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/freq_meter_if.sv | 24 ++
 rtl/freq_meter_sig_sync_edge.sv | 35 +++
 rtl/freq_meter.sv | 162 ++++++++++++++++
 tb/tb_freq_meter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the gated frequency meter.
package freq_meter_pkg;

  localparam int unsigned DEF_GATE_CYCLES = 32_000_000;
  localparam int          DEF_CNT_W       = 26;
  localparam int          GATE_W          = $clog2(DEF_GATE_CYCLES);
  localparam int          SAT_W           = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } fm_state_e;

  // Counters up to SAT_W bits share this helper; callers zero-extend in and truncate out.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_val);
    return (value >= max_val) ? max_val : value + 1'b1;
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle between firmware and freq_meter.
// FREQ_METER_PERIOD_EN adds the period_cnt result.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_cnt;
  logic             overflow;
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] period_cnt;

  modport master (output start, input busy, done, edge_cnt, overflow, period_cnt);
  modport slave  (input start, output busy, done, edge_cnt, overflow, period_cnt);
`else
  modport master (output start, input busy, done, edge_cnt, overflow);
  modport slave  (input start, output busy, done, edge_cnt, overflow);
`endif

endinterface

// File: rtl/freq_meter_sig_sync_edge.sv
// Synchroniser for the asynchronous sig_in plus a registered rising-edge detector.
module sig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_32m,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    rise_d      = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  end

  always_ff @(posedge clk_32m) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      rise_q      <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clk_32m cycles after an arming edge.
// FREQ_METER_PERIOD_EN adds period_cnt (cycles from the arming edge to the first gated edge).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_32m,
  input  logic        rst,
  input  logic        sig_in,
  freq_meter_if.slave bus
);

  localparam int                    GATE_CNT_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_CNT_W-1:0] GATE_LAST  = GATE_CNT_W'(GATE_CYCLES - 1);
  localparam logic [SAT_W-1:0]      CNT_MAX    = SAT_W'((64'd1 << CNT_W) - 64'd1);

  fm_state_e               state_q, state_d;
  logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]        edge_int_q, edge_int_d;
  logic                    ovf_int_q, ovf_int_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    finish;
  logic                    rise;
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0]        period_int_q, period_int_d;
  logic                    period_hit_q, period_hit_d;
  logic [CNT_W-1:0]        period_cnt_q, period_cnt_d;
`endif

  sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_32m (clk_32m),
    .rst     (rst),
    .sig_in  (sig_in),
    .rise    (rise)
  );

  // gate_cnt doubles as the arming timeout in ARM and the gate position in GATE.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_int_d = edge_int_q;
    ovf_int_d  = ovf_int_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    edge_cnt_d = edge_cnt_q;
    overflow_d = overflow_q;
    finish     = 1'b0;
`ifdef FREQ_METER_PERIOD_EN
    period_int_d = period_int_q;
    period_hit_d = period_hit_q;
    period_cnt_d = period_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = ARM;
          busy_d     = 1'b1;
          gate_cnt_d = '0;
          edge_int_d = '0;
          ovf_int_d  = 1'b0;
`ifdef FREQ_METER_PERIOD_EN
          period_int_d = '0;
          period_hit_d = 1'b0;
`endif
        end
      end
      ARM: begin
        if (rise) begin
          state_d    = GATE;
          gate_cnt_d = '0;
        end else if (gate_cnt_q == GATE_LAST) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      GATE: begin
        if (rise) begin
          edge_int_d = CNT_W'(sat_inc(SAT_W'(edge_int_q), CNT_MAX));
          ovf_int_d  = ovf_int_q | (&edge_int_q);
        end
`ifdef FREQ_METER_PERIOD_EN
        // The cycle carrying the first gated edge is still counted, then the count freezes.
        if (!period_hit_q) begin
          period_int_d = period_int_q + 1'b1;
          period_hit_d = rise;
        end
`endif
        if (gate_cnt_q == GATE_LAST) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Results are loaded on entry to DONE so they are valid alongside the done pulse.
    if (finish) begin
      done_d     = 1'b1;
      edge_cnt_d = edge_int_d;
      overflow_d = ovf_int_d;
`ifdef FREQ_METER_PERIOD_EN
      period_cnt_d = period_hit_d ? period_int_d : '0;
`endif
    end
  end

  always_ff @(posedge clk_32m) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_int_q <= '0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_cnt_q <= '0;
      overflow_q <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
      period_int_q <= '0;
      period_hit_q <= 1'b0;
      period_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_int_q <= edge_int_d;
      ovf_int_q  <= ovf_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edge_cnt_q <= edge_cnt_d;
      overflow_q <= overflow_d;
`ifdef FREQ_METER_PERIOD_EN
      period_int_q <= period_int_d;
      period_hit_q <= period_hit_d;
      period_cnt_q <= period_cnt_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.edge_cnt = edge_cnt_q;
  assign bus.overflow = overflow_q;
`ifdef FREQ_METER_PERIOD_EN
  assign bus.period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: a 12-bit instance plus a 3-bit instance for saturation, GATE_CYCLES=1000.
// Period checks are compiled in when FREQ_METER_PERIOD_EN is defined.
module tb_freq_meter;

  localparam int G     = 1000;
  localparam int SAT_M = 7;

  logic clk_32m = 1'b0;
  logic rst;
  logic sig_in;
  int   cyc = 0;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Cycles (negedge timestamps) at which sig_in went from 0 to 1.
  int rise_log[$];
  int gen_mode   = 0;
  int gen_period = 100;
  int gen_high   = 50;
  int gen_ph     = 0;

  typedef struct {
    string name;
    int    mode;
    int    period;
    int    high;
    int    exp_edges;
    int    exp_period;
  } vec_t;

  freq_meter_if #(.CNT_W(12)) bus ();
  freq_meter_if #(.CNT_W(3))  bus_s ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(12), .SYNC_STAGES(2)) dut (
    .clk_32m (clk_32m),
    .rst     (rst),
    .sig_in  (sig_in),
    .bus     (bus)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3), .SYNC_STAGES(2)) dut_sat (
    .clk_32m (clk_32m),
    .rst     (rst),
    .sig_in  (sig_in),
    .bus     (bus_s)
  );

  always #5 clk_32m = ~clk_32m;

  always @(posedge clk_32m) cyc <= cyc + 1;

  // sig_in pattern generator: 0 = held low, 1 = periodic, 2 = random toggles, 3 = single pulse.
  initial begin : gen
    logic nv;
    sig_in = 1'b0;
    forever begin
      @(negedge clk_32m);
      case (gen_mode)
        1:       nv = (gen_ph % gen_period) < gen_high;
        2:       nv = ($urandom_range(0, 2) == 0) ? ~sig_in : sig_in;
        3:       nv = gen_ph < 5;
        default: nv = 1'b0;
      endcase
      gen_ph++;
      if (nv && !sig_in) rise_log.push_back(cyc);
      sig_in = nv;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input int period, input int high);
    gen_mode   = mode;
    gen_period = period;
    gen_high   = high;
    gen_ph     = 0;
  endtask

  task automatic pulseStart(output int s_cyc);
    @(negedge clk_32m);
    bus.start   = 1'b1;
    bus_s.start = 1'b1;
    s_cyc       = cyc + 1;
    @(negedge clk_32m);
    bus.start   = 1'b0;
    bus_s.start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_32m);
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  // Reference: rises reach the FSM 3 cycles after sig_in changes; ARM spans s..s+G-1,
  // the gate spans k+1..k+G after arming rise k, done follows the window.
  task automatic model(input int s, output int exp_done, output int exp_edges, output int exp_period);
    int k;
    k          = -1;
    exp_edges  = 0;
    exp_period = 0;
    foreach (rise_log[i]) begin
      int r;
      r = rise_log[i] + 3;
      if (k < 0) begin
        if (r >= s && r <= s + G - 1) k = r;
      end else if (r > k && r <= k + G) begin
        exp_edges++;
        if (exp_period == 0) exp_period = r - k;
      end
    end
    exp_done = (k < 0) ? s + G : k + G + 1;
  endtask

  // Called at the done cycle; table values of -1 defer to the reference model.
  task automatic checkMeasurement(input string name, input int s, input int done_cyc,
                                  input int tbl_edges, input int tbl_period);
    int m_done, m_edges, m_period, e, p;
    model(s, m_done, m_edges, m_period);
    e = (tbl_edges < 0) ? m_edges : tbl_edges;
    p = (tbl_period < 0) ? m_period : tbl_period;
    checkOutput({name, " done_cycle"}, done_cyc, m_done);
    checkOutput({name, " busy_at_done"}, bus.busy, 1);
    checkOutput({name, " edge_cnt"}, bus.edge_cnt, e);
    checkOutput({name, " overflow"}, bus.overflow, 0);
    checkOutput({name, " sat_done"}, bus_s.done, 1);
    checkOutput({name, " sat_edge_cnt"}, bus_s.edge_cnt, (e > SAT_M) ? SAT_M : e);
    checkOutput({name, " sat_overflow"}, bus_s.overflow, (e > SAT_M) ? 1 : 0);
`ifdef FREQ_METER_PERIOD_EN
    checkOutput({name, " period_cnt"}, bus.period_cnt, p);
`else
    if (p < 0) $display("[TB] unexpected period value for %s", name);
`endif
    @(negedge clk_32m);
    checkOutput({name, " busy_after"}, bus.busy, 0);
    checkOutput({name, " done_after"}, bus.done, 0);
  endtask

  task automatic watchIdle(input string name, input int cycles);
    int dones, busies;
    dones  = 0;
    busies = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_32m);
      if (bus.done !== 1'b0) dones++;
      if (bus.busy !== 1'b0) busies++;
    end
    checkOutput({name, " extra_done"}, dones, 0);
    checkOutput({name, " busy_cycles"}, busies, 0);
  endtask

  initial begin : main
    vec_t tbl[7];
    int   s, dc, p;

    tbl[0] = '{"p100",  1, 100,  50,  10, 100};
    tbl[1] = '{"held0", 0, 0,    0,   0,  0};
    tbl[2] = '{"p20",   1, 20,   10,  50, 20};
    tbl[3] = '{"p1000", 1, 1000, 500, 1,  1000};
    tbl[4] = '{"p8",    1, 8,    1,   125, 8};
    tbl[5] = '{"p3",    1, 3,    2,   333, 3};
    tbl[6] = '{"p2",    1, 2,    1,   500, 2};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus_s.start = 1'b0;
    repeat (5) @(negedge clk_32m);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset edge_cnt", bus.edge_cnt, 0);
    checkOutput("reset overflow", bus.overflow, 0);
    checkOutput("reset sat_edge_cnt", bus_s.edge_cnt, 0);
`ifdef FREQ_METER_PERIOD_EN
    checkOutput("reset period_cnt", bus.period_cnt, 0);
`endif
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].mode, tbl[i].period, tbl[i].high);
      repeat (5 + $urandom_range(0, 50)) @(negedge clk_32m);
      pulseStart(s);
      checkOutput({tbl[i].name, " busy_in_arm"}, bus.busy, 1);
      waitDone(tbl[i].name, 2 * G + 50, dc);
      checkMeasurement(tbl[i].name, s, dc, tbl[i].exp_edges, tbl[i].exp_period);
    end

    $display("[TB] single arming pulse then low");
    applyStimulus(0, 0, 0);
    repeat (10) @(negedge clk_32m);
    pulseStart(s);
    applyStimulus(3, 0, 0);
    waitDone("single_pulse", 2 * G + 50, dc);
    checkMeasurement("single_pulse", s, dc, 0, 0);

    $display("[TB] start while busy and in done cycle");
    applyStimulus(1, 100, 50);
    repeat (20) @(negedge clk_32m);
    pulseStart(s);
    repeat (300) @(negedge clk_32m);
    bus.start   = 1'b1;
    bus_s.start = 1'b1;
    @(negedge clk_32m);
    bus.start   = 1'b0;
    bus_s.start = 1'b0;
    waitDone("restart", 2 * G + 50, dc);
    bus.start   = 1'b1;
    bus_s.start = 1'b1;
    checkMeasurement("restart", s, dc, 10, 100);
    bus.start   = 1'b0;
    bus_s.start = 1'b0;
    watchIdle("restart", 2 * G + 50);

    $display("[TB] reset mid gate");
    pulseStart(s);
    repeat (600) @(negedge clk_32m);
    rst = 1'b1;
    @(negedge clk_32m);
    checkOutput("midrst busy", bus.busy, 0);
    checkOutput("midrst done", bus.done, 0);
    checkOutput("midrst edge_cnt", bus.edge_cnt, 0);
    checkOutput("midrst overflow", bus.overflow, 0);
    checkOutput("midrst sat_overflow", bus_s.overflow, 0);
`ifdef FREQ_METER_PERIOD_EN
    checkOutput("midrst period_cnt", bus.period_cnt, 0);
`endif
    rst = 1'b0;
    watchIdle("midrst", 2 * G + 50);
    pulseStart(s);
    waitDone("after_rst", 2 * G + 50, dc);
    checkMeasurement("after_rst", s, dc, 10, 100);

    $display("[TB] randomized measurements");
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(2, 0, 0);
      end else begin
        p = $urandom_range(2, 300);
        applyStimulus(1, p, $urandom_range(1, p - 1));
      end
      repeat ($urandom_range(3, 200)) @(negedge clk_32m);
      pulseStart(s);
      waitDone($sformatf("rand%0d", i), 2 * G + 50, dc);
      checkMeasurement($sformatf("rand%0d", i), s, dc, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
